// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: shadow-buffered 24-bit colour, committed only at PWM period boundaries.
// Optional gamma shaping of committed duties is enabled by defining RGB_PWM_GAMMA_EN.
module rgb_pwm_driver #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] light,
    input  logic        load,
    output logic        pending,
    output logic        red_pwm,
    output logic        green_pwm,
    output logic        blue_pwm,
    output logic        period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;
    logic          tick;
    logic [7:0]    cnt;
    logic          boundary;
    logic [23:0]   shadow;
    logic [7:0]    act_r;
    logic [7:0]    act_g;
    logic [7:0]    act_b;
    logic          commit_en;
    logic [23:0]   commit_src;

    function automatic logic [7:0] shape(input logic [7:0] d);
        logic [15:0] sq;
`ifdef RGB_PWM_GAMMA_EN
        sq = {8'd0, d} * {8'd0, d};
        if (d == 8'hFF) begin
            return 8'hFF;
        end
        return 8'(sq >> 8);
`else
        sq = {8'd0, d};
        return sq[7:0];
`endif
    endfunction

    always_comb begin
        tick     = (pre == PRE_LAST);
        boundary = tick && (cnt == 8'hFF);
        // A load landing on the boundary bypasses the shadow and goes straight to active.
        commit_en  = boundary && (load || pending);
        commit_src = load ? light : shadow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre          <= '0;
            cnt          <= 8'd0;
            shadow       <= 24'd0;
            act_r        <= 8'd0;
            act_g        <= 8'd0;
            act_b        <= 8'd0;
            pending      <= 1'b0;
            red_pwm      <= 1'b0;
            green_pwm    <= 1'b0;
            blue_pwm     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pre          <= tick ? '0 : pre + 1'b1;
            period_start <= boundary;
            if (tick) begin
                cnt <= cnt + 8'd1;
            end
            if (load) begin
                shadow <= light;
            end
            if (boundary) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
            if (commit_en) begin
                act_r <= shape(commit_src[23:16]);
                act_g <= shape(commit_src[15:8]);
                act_b <= shape(commit_src[7:0]);
            end
            red_pwm   <= (act_r == 8'hFF) | (cnt < act_r);
            green_pwm <= (act_g == 8'hFF) | (cnt < act_g);
            blue_pwm  <= (act_b == 8'hFF) | (cnt < act_b);
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver with PRESCALE=1 (256-cycle periods).
module tb_rgb_pwm_driver;

    typedef struct {
        int r;
        int g;
        int b;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [23:0] light;
    logic        load;
    logic        pending;
    logic        red_pwm;
    logic        green_pwm;
    logic        blue_pwm;
    logic        period_start;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    rgb_pwm_driver #(.PRESCALE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .light        (light),
        .load         (load),
        .pending      (pending),
        .red_pwm      (red_pwm),
        .green_pwm    (green_pwm),
        .blue_pwm     (blue_pwm),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // High cycles per period that a commanded duty should produce.
    function automatic int duty_hi(input logic [7:0] d);
        logic [7:0] e;
        e = d;
`ifdef RGB_PWM_GAMMA_EN
        if (d != 8'hFF) e = 8'(({8'd0, d} * {8'd0, d}) >> 8);
`endif
        return (e == 8'hFF) ? 256 : int'(e);
    endfunction

    task automatic push_exp(input logic [23:0] v);
        exp_t e;
        e.r = duty_hi(v[23:16]);
        e.g = duty_hi(v[15:8]);
        e.b = duty_hi(v[7:0]);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_load(input logic [23:0] v);
        load  = 1'b1;
        light = v;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_ps(input string tag, output int n);
        n = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (period_start) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk({tag, "_timeout"}, 0, 1);
    endtask

    // Starts on the sample where period_start is high; ends on the next such sample.
    task automatic measure(input string tag);
        int   r = 0, g = 0, b = 0, ps = 0;
        int   fr = 0, fg = 0, fb = 0;
        exp_t e;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            if (red_pwm)   begin r++; if (fr == 0) fr = i; end
            if (green_pwm) begin g++; if (fg == 0) fg = i; end
            if (blue_pwm)  begin b++; if (fb == 0) fb = i; end
            if (period_start) ps++;
        end
        chk({tag, "_ps_count"}, ps, 1);
        chk({tag, "_ps_end"}, int'(period_start), 1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_red"}, r, e.r);
            chk({tag, "_green"}, g, e.g);
            chk({tag, "_blue"}, b, e.b);
            if (e.r > 0) chk({tag, "_red_first"}, fr, 1);
            if (e.g > 0) chk({tag, "_green_first"}, fg, 1);
            if (e.b > 0) chk({tag, "_blue_first"}, fb, 1);
        end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        load  = 1'b1;
        light = 24'hFFFFFF;
        idle(3);
        chk("rst_pending", int'(pending), 0);
        chk("rst_outs", int'({red_pwm, green_pwm, blue_pwm, period_start}), 0);
        rst  = 1'b0;
        load = 1'b0;
        idle(1);
        chk("post_rst_outs", int'({pending, red_pwm, green_pwm, blue_pwm}), 0);
        push_exp(24'h000000);
        wait_ps("first_ps", n);
        chk("first_ps_latency", n, 255);
        measure("idle");

        idle(50);
        do_load(24'hFFFFFF);
        chk("full_pending_set", int'(pending), 1);
        push_exp(24'hFFFFFF);
        push_exp(24'hFFFFFF);
        wait_ps("full_ps", n);
        chk("full_pending_clr", int'(pending), 0);
        measure("full1");
        measure("full2");

        idle(30);
        do_load(24'h800040);
        push_exp(24'h800040);
        wait_ps("mix_ps", n);
        measure("mixed");

        idle(10);
        do_load(24'h100000);
        idle(20);
        do_load(24'h200000);
        chk("lw_pending", int'(pending), 1);
        push_exp(24'h200000);
        wait_ps("lw_ps", n);
        measure("last_wins");

        idle(255);
        do_load(24'h000080);
        chk("coinc_ps", int'(period_start), 1);
        chk("coinc_pending", int'(pending), 0);
        push_exp(24'h000080);
        measure("coincident");

        idle(100);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", int'({pending, red_pwm, green_pwm, blue_pwm, period_start}), 0);
        rst = 1'b0;
        wait_ps("midrst_ps", n);
        chk("midrst_restart", n, 256);
        push_exp(24'h000000);
        measure("after_rst");

        idle(40);
        do_load(24'h80FF00);
        push_exp(24'h80FF00);
        wait_ps("gam_ps", n);
        measure("gamma");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Consumer end of the 24-bit light bus produced by the lights selector: turns a coded RGB value into three PWM drive signals for a physical RGB LED.
- New values are captured on a load strobe and held in a shadow register. They are committed only at a PWM period boundary, so a period is never glitched.
- Sits between the selector output and the board LED pins.

Parameters:
- PRESCALE, 4, clock cycles per PWM counter tick (legal values >= 1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- light  input  24  coded colour: [23:16] red, [15:8] green, [7:0] blue duty.
- load  input  1  capture light into the shadow register this cycle.
- pending  output  1  shadow holds an uncommitted value.
- red_pwm  output  1  red drive.
- green_pwm  output  1  green drive.
- blue_pwm  output  1  blue drive.
- period_start  output  1  one-cycle pulse marking a commit/boundary.

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - the prescale counter and the 8-bit pwm counter `cnt`;
  - the shadow register and the active duty registers (all 0);
  - pending, red_pwm, green_pwm, blue_pwm and period_start (all 0).
  Reset asserted mid-period aborts that period and discards any pending value.
- Prescaler: `pre` counts 0..PRESCALE-1 and wraps. `tick` = (pre == PRESCALE-1). With PRESCALE=1, tick is asserted every cycle.
- PWM counter: on tick, `cnt` increments and wraps 255->0. One period is 256*PRESCALE clk cycles.
- Boundary = tick && cnt==255. At a boundary:
  - `cnt` goes to 0.
  - If pending=1, active duty <= shadow and pending <= 0.
  - period_start <= 1 for exactly one cycle. It pulses every boundary, whether or not a commit happens.
- Load:
  - load=1 captures light into the shadow register and sets pending <= 1.
  - Multiple loads before a boundary: the last one wins.
  - load held high: the shadow is rewritten every cycle.
- Load coincident with a boundary: bypass. Active <= light directly, the shadow is written, and pending stays 0.
- Outputs are registered, evaluated every clk:
  - x_pwm <= (active_x == 8'hFF) | (cnt < active_x).
  - duty 0 gives a constant 0.
  - duty 0xFF gives a constant 1 (full white, 24'hFFFFFF, means fully on).
  - duty N (1..254) gives high for N ticks per period.
  - Outputs lag the counter by one clk.
- Channels are independent; no arithmetic beyond 8-bit unsigned compare.

Optional Feature:
- Macro: RGB_PWM_GAMMA_EN.
- Defined:
  - At commit time, each channel duty d becomes (d*d)>>8, computed in 16 bits and taking the upper byte.
  - d=0xFF is forced to 0xFF.
  - The shadow and pending behaviour is unchanged; the gamma mapping is applied on both the commit path and the bypass path.
- Undefined: duty is used linearly as given.

Test Plan (PRESCALE=1, period 256 cycles, macro undefined unless stated):
- Reset: rst=1 for 3 cycles with load=1 and light=24'hFFFFFF -> all outputs 0, pending=0; after release, outputs stay 0 until a load followed by a boundary.
- Full on: load 24'hFFFFFF mid-period -> pending=1 until the boundary, then pending=0. From the cycle after commit, all three PWM outputs are constantly 1. period_start pulses exactly once per 256 cycles.
- Mixed duty: commit 24'h800040 -> per 256-cycle period, red_pwm is high for 128 cycles, green_pwm for 0, blue_pwm for 64. Highs start the cycle after period_start.
- Last-wins: load 24'h100000 then 24'h200000 within one period -> next period red is high for 32 cycles; 0x10 is never observed.
- Coincident load: load 24'h000080 in the boundary cycle -> pending stays 0; the following period has blue high for 128 cycles.
- Mid-period reset, then gamma:
  - Assert rst at cnt=100 -> outputs 0 next cycle, counter restarts at 0, the old duty is lost.
  - With RGB_PWM_GAMMA_EN, commit 24'h80FF00 -> red high 64 cycles, green constant 1, blue 0.
